rvvi_trace_emitter: RTL and testbench

Producer side of the RVVI trace interface: accepts retirement events from the core over a valid/ready handshake, buffers them in a small FIFO, and drives the hart-0, retire-slot-0 trace fields, one retirement per cycle, in program order. The coverage collector samples these fields. A thin wrapper assigns the flat outputs to `valid[0][0]`, `pc_rdata[0][0]`, `insn[0][0]`, `trap[0][0]` and `order[0][0]`. A stall input lets the trace consumer pause emission without losing events.

---
 rtl/rvvi_trace_pkg.sv | 23 ++
 rtl/rvvi_trace_emitter_if.sv | 56 +++++
 rtl/rvvi_trace_fifo.sv | 77 +++++++
 rtl/rvvi_trace_emitter.sv | 120 ++++++++++++
 tb/tb_rvvi_trace_emitter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rvvi_trace_pkg.sv
// rvvi_trace_pkg: shared types and constants for the RVVI trace emitter.
//   ORDER_W      width of the retirement sequence number (trace_order)
//   XLEN_DEF     default PC / writeback data width
//   ILEN_DEF     default instruction width
//   ret_entry_t  one buffered retirement event at the default widths; it is
//                also the default entry type of rvvi_trace_fifo, whose width
//                follows whatever entry type the instantiating module passes.
package rvvi_trace_pkg;

  localparam int ORDER_W  = 64;
  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] insn;
    logic                trap;
    logic [4:0]          rd;
    logic                rd_we;
    logic [XLEN_DEF-1:0] rd_wdata;
  } ret_entry_t;

endpackage

// File: rtl/rvvi_trace_emitter_if.sv
// rvvi_trace_emitter_if: retirement input and trace output bundle.
//
// Handshake: an event transfers on a clock edge where ret_valid and ret_ready
// are both high and flush is low. ret_ready depends only on registered
// occupancy (never on ret_valid, flush or trace_stall). The producer holds the
// event fields stable while ret_valid is high and not yet accepted.
// The trace side has no backpressure other than trace_stall: trace_valid is a
// one-cycle strobe per emitted event and must be sampled every cycle.
//
// Modports:
//   master - core / retirement producer and trace consumer control
//   slave  - the emitter (rvvi_trace_emitter)
import rvvi_trace_pkg::*;

interface rvvi_trace_emitter_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               ret_valid;
  logic               ret_ready;
  logic [XLEN-1:0]    ret_pc;
  logic [ILEN-1:0]    ret_insn;
  logic               ret_trap;
  logic [4:0]         ret_rd;
  logic               ret_rd_we;
  logic [XLEN-1:0]    ret_rd_wdata;
  logic               flush;
  logic               trace_stall;
  logic               trace_valid;
  logic [XLEN-1:0]    trace_pc;
  logic [ILEN-1:0]    trace_insn;
  logic               trace_trap;
  logic [4:0]         trace_rd;
  logic               trace_rd_we;
  logic [XLEN-1:0]    trace_rd_wdata;
  logic [ORDER_W-1:0] trace_order;
  logic [CW-1:0]      trace_count;

  modport master (
    output ret_valid, ret_pc, ret_insn, ret_trap, ret_rd, ret_rd_we,
           ret_rd_wdata, flush, trace_stall,
    input  ret_ready, trace_valid, trace_pc, trace_insn, trace_trap,
           trace_rd, trace_rd_we, trace_rd_wdata, trace_order, trace_count
  );

  modport slave (
    input  ret_valid, ret_pc, ret_insn, ret_trap, ret_rd, ret_rd_we,
           ret_rd_wdata, flush, trace_stall,
    output ret_ready, trace_valid, trace_pc, trace_insn, trace_trap,
           trace_rd, trace_rd_we, trace_rd_wdata, trace_order, trace_count
  );

endinterface

// File: rtl/rvvi_trace_fifo.sv
// rvvi_trace_fifo: retirement event storage.
//   clk, reset_n  clock, async active-low reset
//   push, wr_data write one entry (caller guarantees !full)
//   pop           read one entry (caller guarantees !empty); rd_data is the
//                 head entry, valid combinationally whenever !empty
//   flush         clears pointers and count at the next edge; wins over
//                 push/pop in the same cycle
//   count         occupancy, 0..DEPTH
//   full, empty   derived from registered count only
import rvvi_trace_pkg::*;

module rvvi_trace_fifo #(
  parameter type entry_t = ret_entry_t,
  parameter int  DEPTH   = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  entry_t        wr_data,
  input  logic          pop,
  input  logic          flush,
  output entry_t        rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read while count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/rvvi_trace_emitter.sv
// rvvi_trace_emitter: RVVI trace producer for hart 0, retire slot 0.
// Buffers retirement events and emits at most one per cycle, in order.
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      rvvi_trace_emitter_if.slave: ret_* input handshake, flush,
//            trace_stall, trace_* registered outputs, trace_count occupancy
// Optional feature: `RVVI_ORDER_EN adds the 64-bit retirement order counter;
// without it trace_order is tied to zero.
import rvvi_trace_pkg::*;

module rvvi_trace_emitter #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  rvvi_trace_emitter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
    logic            trap;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] rd_wdata;
  } entry_t;

  entry_t        wr_entry;
  entry_t        rd_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  entry_t out_q,   out_d;
  logic   valid_q, valid_d;

  assign wr_entry = '{pc:       bus.ret_pc,
                      insn:     bus.ret_insn,
                      trap:     bus.ret_trap,
                      rd:       bus.ret_rd,
                      rd_we:    bus.ret_rd_we,
                      rd_wdata: bus.ret_rd_wdata};

  // A push offered together with flush is dropped even though ret_ready
  // may be high; the producer is expected to know it issued the flush.
  assign push = bus.ret_valid && !full && !bus.flush;
  assign pop  = !empty && !bus.trace_stall && !bus.flush;

  rvvi_trace_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .flush   (bus.flush),
    .rd_data (rd_entry),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Output stage: fields load only on pop and otherwise hold; valid is a
  // single-cycle strobe per popped event.
  always_comb begin
    out_d   = out_q;
    valid_d = pop;
    if (pop) out_d = rd_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

`ifdef RVVI_ORDER_EN
  // Counts pops since reset; the value after a pop is that event's order,
  // so the first event carries 1. Flush leaves it untouched.
  logic [ORDER_W-1:0] order_q, order_d;

  always_comb begin
    order_d = order_q;
    if (pop) order_d = order_q + ORDER_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) order_q <= '0;
    else          order_q <= order_d;
  end

  assign bus.trace_order = order_q;
`else
  assign bus.trace_order = '0;
`endif

  // Depends on registered count only, so trace_stall never reaches it.
  assign bus.ret_ready      = !full;
  assign bus.trace_valid    = valid_q;
  assign bus.trace_pc       = out_q.pc;
  assign bus.trace_insn     = out_q.insn;
  assign bus.trace_trap     = out_q.trap;
  assign bus.trace_rd       = out_q.rd;
  assign bus.trace_rd_we    = out_q.rd_we;
  assign bus.trace_rd_wdata = out_q.rd_wdata;
  assign bus.trace_count    = count;

endmodule

// File: tb/tb_rvvi_trace_emitter.sv
// tb_rvvi_trace_emitter: directed bench for rvvi_trace_emitter.
// Inputs change 1 time unit after the rising edge; outputs are read either
// 1 unit after the edge (directed checks) or on the falling edge (scoreboard).
module tb_rvvi_trace_emitter;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rvvi_trace_emitter_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  rvvi_trace_emitter #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  logic [63:0] next_order = 64'd1;
  logic [XLEN:0] exp_q[$];   // {trap, pc} of each accepted, unflushed event

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ord(input logic [63:0] n);
`ifdef RVVI_ORDER_EN
    return n;
`else
    return 64'd0 & n;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && bus.trace_valid) begin
      logic [XLEN:0] e;
      valid_seen++;
      check("sb_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc",    bus.trace_pc,          e[XLEN-1:0]);
        check("sb_trap",  64'(bus.trace_trap),   64'(e[XLEN]));
        check("sb_order", bus.trace_order,       ord(next_order));
        next_order = next_order + 64'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [XLEN-1:0] pc, input logic [ILEN-1:0] insn,
                       input logic trap, input logic [4:0] rd,
                       input logic we, input logic [XLEN-1:0] wdata);
    bus.ret_valid    = 1'b1;
    bus.ret_pc       = pc;
    bus.ret_insn     = insn;
    bus.ret_trap     = trap;
    bus.ret_rd       = rd;
    bus.ret_rd_we    = we;
    bus.ret_rd_wdata = wdata;
  endtask

  // Offer one event for one edge; queue it as expected if it will be taken.
  task automatic offer(input logic [XLEN-1:0] pc, input logic trap);
    drive(pc, 32'h0000_0013, trap, 5'd0, 1'b0, '0);
    if (bus.ret_ready && !bus.flush) exp_q.push_back({trap, pc});
    step();
  endtask

  task automatic idle();
    bus.ret_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    bus.ret_valid = 1'b0; bus.ret_pc = '0; bus.ret_insn = '0;
    bus.ret_trap = 1'b0; bus.ret_rd = '0; bus.ret_rd_we = 1'b0;
    bus.ret_rd_wdata = '0; bus.flush = 1'b0; bus.trace_stall = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.trace_valid), 64'd0);
    check("rst_pc",    bus.trace_pc,         64'd0);
    check("rst_insn",  64'(bus.trace_insn),  64'd0);
    check("rst_order", bus.trace_order,      64'd0);
    check("rst_count", 64'(bus.trace_count), 64'd0);
    check("rst_ready", 64'(bus.ret_ready),   64'd1);
    reset_n = 1'b1;
    step();

    // 1: single event, visible after the second edge for one cycle
    drive(64'h8000_0000, 32'h0010_0093, 1'b0, 5'd1, 1'b1, 64'd1);
    exp_q.push_back({1'b0, 64'h8000_0000});
    step();
    check("t1_valid_early", 64'(bus.trace_valid), 64'd0);
    check("t1_count",       64'(bus.trace_count), 64'd1);
    idle();
    step();
    check("t1_valid", 64'(bus.trace_valid), 64'd1);
    check("t1_pc",    bus.trace_pc,         64'h8000_0000);
    check("t1_insn",  64'(bus.trace_insn),  64'h0010_0093);
    check("t1_rd",    64'(bus.trace_rd),    64'd1);
    check("t1_rd_we", 64'(bus.trace_rd_we), 64'd1);
    check("t1_wdata", bus.trace_rd_wdata,   64'd1);
    check("t1_order", bus.trace_order,      ord(64'd1));
    step();
    check("t1_valid_off", 64'(bus.trace_valid), 64'd0);
    check("t1_pc_hold",   bus.trace_pc,         64'h8000_0000);

    // 2: ten back-to-back events, continuous emission
    for (int i = 0; i < 10; i++) begin
      check("b2b_ready", 64'(bus.ret_ready), 64'd1);
      offer(64'h1000 + 64'(4 * i), 1'b0);
      if (i > 0) check("b2b_valid", 64'(bus.trace_valid), 64'd1);
    end
    idle();
    step();
    check("b2b_last_valid", 64'(bus.trace_valid), 64'd1);
    check("b2b_last_order", bus.trace_order,      ord(64'd11));
    step();
    check("b2b_end", 64'(bus.trace_valid), 64'd0);

    // 3: stall for 6 offers; only DEPTH accepted, then drained in order
    bus.trace_stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ret_ready) acc++;
      offer(64'h2000 + 64'(4 * i), 1'b0);
      check("st_no_valid", 64'(bus.trace_valid), 64'd0);
    end
    check("st_accepted", 64'(acc),             64'd4);
    check("st_count",    64'(bus.trace_count), 64'd4);
    check("st_ready",    64'(bus.ret_ready),   64'd0);
    idle();
    bus.trace_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_drain_valid", 64'(bus.trace_valid), 64'd1);
    end
    step();
    check("st_drain_end", 64'(bus.trace_valid), 64'd0);
    check("st_ready_back", 64'(bus.ret_ready),  64'd1);

    // 4: flush three buffered events plus a same-cycle offer
    bus.trace_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(64'h3000 + 64'(4 * i), 32'h13, 1'b0, 5'd0, 1'b0, '0);
      step();
    end
    check("fl_count_pre", 64'(bus.trace_count), 64'd3);
    bus.trace_stall = 1'b0;
    bus.flush = 1'b1;
    drive(64'h3333, 32'h13, 1'b0, 5'd0, 1'b0, '0);
    step();
    check("fl_count", 64'(bus.trace_count), 64'd0);
    check("fl_valid", 64'(bus.trace_valid), 64'd0);
    check("fl_ready", 64'(bus.ret_ready),   64'd1);
    bus.flush = 1'b0;
    idle();
    step();
    check("fl_quiet", 64'(bus.trace_valid), 64'd0);
    offer(64'h4000, 1'b0);
    idle();
    step();
    check("fl_next_valid", 64'(bus.trace_valid), 64'd1);
    check("fl_next_order", bus.trace_order,      ord(64'd16));
    step();

    // 5: trapped event then handler
    offer(64'h8000_0040, 1'b1);
    offer(64'h8000_0100, 1'b0);
    check("tr_trap_first", 64'(bus.trace_trap), 64'd1);
    check("tr_order_1",    bus.trace_order,     ord(64'd17));
    idle();
    step();
    check("tr_trap_second", 64'(bus.trace_trap), 64'd0);
    check("tr_pc_handler",  bus.trace_pc,        64'h8000_0100);
    check("tr_order_2",     bus.trace_order,     ord(64'd18));
    step();

    // 6: reset mid-burst
    for (int i = 0; i < 3; i++) offer(64'h5000 + 64'(4 * i), 1'b0);
    idle();
    reset_n = 1'b0;
    exp_q.delete();
    next_order = 64'd1;
    #1;
    check("mr_valid", 64'(bus.trace_valid), 64'd0);
    check("mr_pc",    bus.trace_pc,         64'd0);
    check("mr_trap",  64'(bus.trace_trap),  64'd0);
    check("mr_wdata", bus.trace_rd_wdata,   64'd0);
    check("mr_order", bus.trace_order,      64'd0);
    check("mr_count", 64'(bus.trace_count), 64'd0);
    check("mr_ready", 64'(bus.ret_ready),   64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    offer(64'h6000, 1'b0);
    idle();
    step();
    check("mr_post_valid", 64'(bus.trace_valid), 64'd1);
    check("mr_post_order", bus.trace_order,      ord(64'd1));
    step();
    step();

    // events emitted: 1 + 10 + 4 + 1 + 2 + 1 (before reset) + 1
    check("sb_drain",   64'(exp_q.size()), 64'd0);
    check("sb_emitted", 64'(valid_seen),   64'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
